axi_write_arbiter: RTL

//  Shares one downstream AXI-lite write slave (AW/W/B channels) between NUM_M upstream AXI-lite masters.

---
 rtl/axi_lite_pkg.sv | 25 ++
 rtl/axi_write_arbiter_rr_pick.sv | 29 ++
 rtl/axi_write_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions for the write arbiter: response codes, the
// arbiter FSM state encoding and a small round-robin pointer helper.
package axi_lite_pkg;

    // Write response codes carried on BRESP.
    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    // One write transaction walks IDLE -> ADDR -> DATA -> RESP -> IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_state_t;

    // Round-robin successor of a granted index: the master after the one
    // just served gets first look next time, wrapping at the last master.
    function automatic int rr_next(input int granted, input int num_m);
        return (granted == num_m - 1) ? 0 : granted + 1;
    endfunction

endpackage

// File: rtl/axi_write_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index found
// when searching upward from ptr with wrap-around.
module rr_pick #(
    parameter  int NUM_M = 2,
    localparam int PW    = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    gnt_idx,
    output logic             gnt_any
);

    // Scan NUM_M candidate positions starting at ptr; the first hit wins.
    always_comb begin
        logic [PW-1:0] idx;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned, which would infer a latch.
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int off = 0; off < NUM_M; off++) begin
            idx = PW'((int'(ptr) + off) % NUM_M);
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI-lite write slave between NUM_M masters.
// A complete AW -> W -> B transaction is granted at a time; the FSM, grant and
// round-robin pointer are registered and all channel steering is combinational
// from the registered grant.
module axi_write_arbiter
    import axi_lite_pkg::*;
#(
    parameter  int NUM_M = 2,
    parameter  int AW    = 32,
    parameter  int DW    = 32,
    localparam int GW    = $clog2(NUM_M)
) (
    input  logic                ACLK,
    input  logic                ARESETN,

    input  logic [NUM_M-1:0]    s_awvalid,
    input  logic [NUM_M*AW-1:0] s_awaddr,
    output logic [NUM_M-1:0]    s_awready,
    input  logic [NUM_M-1:0]    s_wvalid,
    input  logic [NUM_M*DW-1:0] s_wdata,
    output logic [NUM_M-1:0]    s_wready,
    input  logic [NUM_M-1:0]    s_bready,
    output logic [NUM_M-1:0]    s_bvalid,
    output logic [NUM_M*2-1:0]  s_bresp,

    output logic                m_awvalid,
    output logic [AW-1:0]       m_awaddr,
    input  logic                m_awready,
    output logic                m_wvalid,
    output logic [DW-1:0]       m_wdata,
    input  logic                m_wready,
    output logic                m_bready,
    input  logic                m_bvalid,
    input  logic [1:0]          m_bresp,

    output logic [GW-1:0]       grant_id,
    output logic                busy
);

    wr_state_t     state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] pick_idx;
    logic          pick_any;

    rr_pick #(
        .NUM_M (NUM_M)
    ) u_rr_pick (
        .req     (s_awvalid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Sequencing of one granted transaction and round-robin pointer update.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates from the values seen before the edge.
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_awvalid && m_awready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (m_wvalid && m_wready) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (m_bvalid && m_bready) begin
                        rr_ptr <= GW'(rr_next(int'(grant_id), NUM_M));
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Busy covers the whole granted transaction, i.e. every non-IDLE state.
    assign busy = (state != IDLE);

    // Channel steering: only the phase matching the state is connected, only
    // for the granted master; everything else is driven to zero.
    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_bresp   = '0;
        m_awvalid = 1'b0;
        m_awaddr  = '0;
        m_wvalid  = 1'b0;
        m_wdata   = '0;
        m_bready  = 1'b0;
        case (state)
            ADDR: begin
                m_awvalid           = s_awvalid[grant_id];
                m_awaddr            = s_awaddr[int'(grant_id)*AW +: AW];
                s_awready[grant_id] = m_awready;
            end
            DATA: begin
                m_wvalid           = s_wvalid[grant_id];
                m_wdata            = s_wdata[int'(grant_id)*DW +: DW];
                s_wready[grant_id] = m_wready;
            end
            RESP: begin
                s_bvalid[grant_id]               = m_bvalid;
                s_bresp[int'(grant_id)*2 +: 2]   = m_bresp;
                m_bready                         = s_bready[grant_id];
            end
            default: begin
            end
        endcase
    end

endmodule
